program_loader: RTL



---
 rtl/program_loader_pkg.sv | 12 +
 rtl/loader_word_assembler.sv | 48 ++++
 rtl/program_loader.sv | 114 +++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// Constants shared by the program loader and the debug unit.
package program_loader_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_LOAD  = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;
  localparam logic [1:0] ST_ERROR = 2'b11;

  localparam logic [31:0]  HALT_INSTR      = 32'hFFFF_FFFF;
  localparam int unsigned  BYTES_PER_INSTR = 4;

endpackage

// File: rtl/loader_word_assembler.sv
// Big-endian byte-to-word assembler; flags a word-aligned HALT as its last byte arrives.
module loader_word_assembler #(
  parameter int unsigned                      MEMORY_WIDTH   = 8,
  parameter int unsigned                      NB_INSTRUCTION = 32,
  parameter logic [NB_INSTRUCTION-1:0]        HALT_WORD      = '1
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    clear_i,
  input  logic                    shift_i,
  input  logic [MEMORY_WIDTH-1:0] byte_i,
  output logic                    is_halt_c_o
);
  import program_loader_pkg::*;

  localparam int unsigned SH_W   = NB_INSTRUCTION - MEMORY_WIDTH;
  localparam int unsigned LANE_W = $clog2(BYTES_PER_INSTR);

  logic [SH_W-1:0]   shift_q, shift_d;
  logic [LANE_W-1:0] lane_q, lane_d;

  always_comb begin
    shift_d = shift_q;
    lane_d  = lane_q;
    if (clear_i) begin
      shift_d = '0;
      lane_d  = '0;
    end else if (shift_i) begin
      shift_d = {shift_q[SH_W-MEMORY_WIDTH-1:0], byte_i};
      lane_d  = lane_q + LANE_W'(1);
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      shift_q <= '0;
      lane_q  <= '0;
    end else begin
      shift_q <= shift_d;
      lane_q  <= lane_d;
    end
  end

  // Only the last lane of a word can complete a HALT; straddling patterns never match.
  assign is_halt_c_o = (lane_q == LANE_W'(BYTES_PER_INSTR - 1)) &&
                       ({shift_q, byte_i} == HALT_WORD);

endmodule

// File: rtl/program_loader.sv
// Streams UART bytes into instruction memory until a word-aligned HALT or overflow.
module program_loader #(
  parameter int unsigned               MEMORY_WIDTH   = 8,
  parameter int unsigned               MEMORY_DEPTH   = 64,
  parameter int unsigned               NB_ADDR        = 32,
  parameter int unsigned               NB_INSTRUCTION = 32,
  parameter logic [NB_INSTRUCTION-1:0] HALT_INSTR     = program_loader_pkg::HALT_INSTR
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_start_load,
  input  logic                    i_rx_done,
  input  logic [MEMORY_WIDTH-1:0] i_rx_data,
  output logic                    o_write_enable,
  output logic [MEMORY_WIDTH-1:0] o_write_data,
  output logic [NB_ADDR-1:0]      o_write_addr,
  output logic                    o_busy,
  output logic                    o_load_done,
  output logic                    o_error
);
  import program_loader_pkg::*;

  localparam int unsigned CNT_W = $clog2(MEMORY_DEPTH) + 1;

  logic [1:0]              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [MEMORY_WIDTH-1:0] wdata_q, wdata_d;
  logic [NB_ADDR-1:0]      waddr_q, waddr_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    asm_clear, asm_shift, is_halt_c;

  loader_word_assembler #(
    .MEMORY_WIDTH   (MEMORY_WIDTH),
    .NB_INSTRUCTION (NB_INSTRUCTION),
    .HALT_WORD      (HALT_INSTR)
  ) u_word_assembler (
    .clock_i     (i_clock),
    .reset_i     (i_reset),
    .clear_i     (asm_clear),
    .shift_i     (asm_shift),
    .byte_i      (i_rx_data),
    .is_halt_c_o (is_halt_c)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = 1'b0;
    wdata_d   = wdata_q;
    waddr_d   = waddr_q;
    asm_clear = 1'b0;
    asm_shift = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (i_rx_done) begin
          if (cnt_q < CNT_W'(MEMORY_DEPTH)) begin
            we_d      = 1'b1;
            wdata_d   = i_rx_data;
            waddr_d   = NB_ADDR'(cnt_q);
            cnt_d     = cnt_q + CNT_W'(1);
            asm_shift = 1'b1;
            if (is_halt_c) state_d = ST_DONE;
          end else begin
            state_d = ST_ERROR;
          end
        end
      end
      // IDLE, DONE and ERROR drop bytes and restart a fresh load on request.
      default: begin
        if (i_start_load) begin
          state_d   = ST_LOAD;
          cnt_d     = '0;
          asm_clear = 1'b1;
        end
      end
    endcase
    busy_d = (state_d == ST_LOAD);
    done_d = (state_d == ST_DONE);
    err_d  = (state_d == ST_ERROR);
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      waddr_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign o_write_enable = we_q;
  assign o_write_data   = wdata_q;
  assign o_write_addr   = waddr_q;
  assign o_busy         = busy_q;
  assign o_load_done    = done_q;
  assign o_error        = err_q;

endmodule
